// File: rtl/cmp_reduce.sv
// Per-lane min/max reduction over len beats, with optional argmin/argmax (CMP_REDUCE_ARGIDX_EN).
// Latency: result valid 1 cycle after last beat; in_ready only in ACC, result held until out_ready.
module cmp_reduce #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_LANES  = 4,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [LEN_WIDTH-1:0]            len,
   input  logic                            op_max,
   input  logic                            is_signed,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
   output logic [NUM_LANES*LEN_WIDTH-1:0]  out_idx,
   output logic                            busy
);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t               state, state_nx;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] cnt;
   logic                 op_max_q;
   logic                 signed_q;
   logic                 accept;
   logic                 last_beat;
   logic                 launch;

   assign launch    = (state == IDLE) && start && (len != '0);
   assign accept    = (state == ACC) && in_valid;
   assign last_beat = accept && (cnt == len_q - LEN_WIDTH'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (launch) state_nx = ACC;
         end
         ACC: begin
            in_ready = 1'b1;
            if (last_beat) state_nx = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // cnt stops at len after the last beat, so len = 2^LEN_WIDTH-1 never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q    <= '0;
         op_max_q <= 1'b0;
         signed_q <= 1'b0;
         cnt      <= '0;
      end else if (launch) begin
         len_q    <= len;
         op_max_q <= op_max;
         signed_q <= is_signed;
         cnt      <= '0;
      end else if (accept) begin
         cnt <= cnt + LEN_WIDTH'(1);
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] din;
      logic [DATA_WIDTH-1:0] cur;
      logic                  gt;
      logic                  lt;
      logic                  take;

      assign din  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign gt   = signed_q ? ($signed(din) > $signed(cur)) : (din > cur);
      assign lt   = signed_q ? ($signed(din) < $signed(cur)) : (din < cur);
      // Strict compare: ties keep the earlier beat.
      assign take = accept && ((cnt == '0) || (op_max_q ? gt : lt));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cur <= '0;
         end else if (take) begin
            cur <= din;
         end
      end

      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = cur;

`ifdef CMP_REDUCE_ARGIDX_EN
      logic [LEN_WIDTH-1:0] idx;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            idx <= '0;
         end else if (take) begin
            idx <= cnt;
         end
      end

      assign out_idx[i*LEN_WIDTH +: LEN_WIDTH] = idx;
`else
      assign out_idx[i*LEN_WIDTH +: LEN_WIDTH] = '0;
`endif
   end

endmodule

// File: tb/tb_cmp_reduce.sv
// Directed bench for cmp_reduce: vector table plus hand sequences for backpressure, len=0, reset, len=max.
module tb_cmp_reduce;

`ifdef CMP_REDUCE_ARGIDX_EN
   localparam bit IDX_EN = 1'b1;
`else
   localparam bit IDX_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  len;
   logic        op_max;
   logic        is_signed;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [31:0] out_idx;
   logic        busy;

   int checks = 0;
   int errors = 0;

   cmp_reduce #(.DATA_WIDTH(8), .NUM_LANES(4), .LEN_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .op_max(op_max),
      .is_signed(is_signed), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]       len;
      logic             op_max;
      logic             is_signed;
      logic [3:0][31:0] beats;
      logic [31:0]      exp_data;
      logic [31:0]      exp_idx;
   } vec_t;

   vec_t tv[6];

   function automatic vec_t mk(input logic [7:0] l, input logic om, input logic sg,
                               input logic [31:0] b0, input logic [31:0] b1,
                               input logic [31:0] b2, input logic [31:0] b3,
                               input logic [31:0] d, input logic [31:0] ix);
      vec_t v;
      v.len = l; v.op_max = om; v.is_signed = sg;
      v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
      v.exp_data = d;
      v.exp_idx  = IDX_EN ? ix : 32'h0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [7:0] l, input logic om, input logic sg);
      start = 1'b1; len = l; op_max = om; is_signed = sg;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic finish_chk(input string name, input logic [31:0] d, input logic [31:0] ix);
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_data"}, 64'(out_data), 64'(d));
      chk({name, "_idx"}, 64'(out_idx), 64'(ix));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_idle"}, {62'd0, out_valid, busy}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, n;
      logic tog, rdy;

      // len, op_max, signed, beats 0..3, expected data, expected idx ({lane3..lane0})
      tv[0] = mk(8'd3, 1'b1, 1'b0, 32'h01020305, 32'h010204F0, 32'h01020310, 32'h0,
                 32'h010204F0, 32'h00000101);
      tv[1] = mk(8'd3, 1'b0, 1'b1, 32'h1000057F, 32'h1000F081, 32'h10FF8000, 32'h0,
                 32'h10FF8081, 32'h00020201);
      tv[2] = mk(8'd3, 1'b0, 1'b0, 32'h1000057F, 32'h1000F081, 32'h10FF8000, 32'h0,
                 32'h10000500, 32'h00000002);
      tv[3] = mk(8'd4, 1'b1, 1'b0, 32'h0007FF00, 32'h00090000, 32'h00090000, 32'h00030001,
                 32'h0009FF01, 32'h00010003);
      tv[4] = mk(8'd2, 1'b1, 1'b1, 32'hFE7F80FF, 32'hFF807F01, 32'h0, 32'h0,
                 32'hFF7F7F01, 32'h01000101);
      tv[5] = mk(8'd1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0,
                 32'hDEADBEEF, 32'h00000000);

      reset = 1'b1; start = 1'b0; len = '0; op_max = 1'b0; is_signed = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      chk("reset_ctrl", {61'd0, busy, in_ready, out_valid}, 64'd0);
      chk("reset_data", {out_idx, out_data}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int v = 0; v < 6; v++) begin
         start_op(tv[v].len, tv[v].op_max, tv[v].is_signed);
         chk($sformatf("v%0d_acc", v), {62'd0, busy, in_ready}, 64'd3);
         for (int b = 0; b < int'(tv[v].len); b++) begin
            chk($sformatf("v%0d_novalid_b%0d", v, b), 64'(out_valid), 64'd0);
            send(tv[v].beats[b]);
         end
         finish_chk($sformatf("v%0d", v), tv[v].exp_data, tv[v].exp_idx);
      end

      // toggling in_valid, held result, start and config changes ignored
      start_op(8'd3, 1'b1, 1'b0);
      op_max = 1'b0; is_signed = 1'b1;
      k = 0; n = 0; tog = 1'b0;
      while (k < 3 && n < 40) begin
         rdy = in_ready;
         tog = ~tog;
         in_valid = tog;
         in_data = tv[0].beats[k];
         @(negedge clk);
         if (tog && rdy) k++;
         n++;
      end
      in_valid = 1'b0;
      chk("bp_beats", 64'(k), 64'd3);
      for (int c = 0; c < 5; c++) begin
         start = 1'b1; len = 8'd2; in_valid = c[0];
         @(negedge clk);
         chk($sformatf("bp_hold%0d", c), {31'd0, out_valid, out_data}, {31'd0, 1'b1, tv[0].exp_data});
         chk($sformatf("bp_idx%0d", c), 64'(out_idx), 64'(tv[0].exp_idx));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_hs_start_ignored", {62'd0, busy, out_valid}, 64'd0);
      start = 1'b0;
      @(negedge clk);
      chk("bp_still_idle", {62'd0, busy, in_ready}, 64'd0);

      // len=0 start is ignored
      start_op(8'd0, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("len0_c%0d", c), {61'd0, busy, in_ready, out_valid}, 64'd0);
         @(negedge clk);
      end

      // reset mid-ACC discards result; first start after release honoured
      start_op(8'd4, 1'b1, 1'b0);
      send(32'h11111111);
      send(32'h22222222);
      chk("rst_pre_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_async_ctrl", {61'd0, busy, in_ready, out_valid}, 64'd0);
      chk("rst_async_data", {out_idx, out_data}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      start_op(8'd1, 1'b1, 1'b0);
      chk("rst_restart_busy", {62'd0, busy, out_valid}, 64'd2);
      send(32'h12345678);
      finish_chk("rst_fresh", 32'h12345678, 32'h0);

      // reset while OUT is pending
      start_op(8'd1, 1'b0, 1'b0);
      send(32'hAAAAAAAA);
      chk("rst_out_pending", 64'(out_valid), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst_out_gone%0d", c), {62'd0, busy, out_valid}, 64'd0);
      end

      // maximum len: 255 beats, no counter wrap
      start_op(8'd255, 1'b1, 1'b0);
      for (int b = 0; b < 255; b++) begin
         logic [7:0] l0, l1, l3;
         l0 = 8'(b);
         l1 = 8'(255 - b);
         l3 = (b == 100) ? 8'h80 : 8'h00;
         if (b == 254) chk("max_novalid", 64'(out_valid), 64'd0);
         send({l3, 8'h05, l1, l0});
      end
      finish_chk("maxlen", 32'h8005FFFE, IDX_EN ? 32'h640000FE : 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmp_reduce.md
CMP_REDUCE -- requirements
Module: cmp_reduce

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter NUM_LANES, default 4, independent compare lanes.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, width of the beat counter and of each index.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request a new reduction; sampled only in IDLE.
REQ-007 SHALL have port len  input  LEN_WIDTH  beats to reduce; latched on accepted start.
REQ-008 SHALL have port op_max  input  1  1 = max reduction, 0 = min; latched on accepted start.
REQ-009 SHALL have port is_signed  input  1  1 = two's-complement compare, 0 = unsigned; latched on accepted start.
REQ-010 SHALL have port in_valid  input  1  input beat valid.
REQ-011 SHALL have port in_ready  output  1  block accepts a beat.
REQ-012 SHALL have port in_data  input  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port out_valid  output  1  result available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port out_data  output  NUM_LANES*DATA_WIDTH  per-lane extreme value.
REQ-016 SHALL have port out_idx  output  NUM_LANES*LEN_WIDTH  per-lane beat index of the extreme (see REQ-034).
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement three states: IDLE, ACC, OUT.
REQ-019 IDLE: start=1 and len!=0 SHALL latch len/op_max/is_signed, clear beat counter, and go to ACC the next cycle.
REQ-020 IDLE: start=1 with len=0 SHALL be ignored; state stays IDLE, no output produced.
REQ-021 start SHALL be ignored in ACC and OUT; latched configuration SHALL not change until the next IDLE start.
REQ-022 in_ready SHALL be 1 exactly in ACC; a beat is accepted when in_valid and in_ready are both 1.
REQ-023 First accepted beat (count 0) SHALL load every lane unconditionally, with index 0.
REQ-024 Each later beat SHALL replace lane i only if strictly greater (op_max=1) or strictly less (op_max=0) than stored; ties SHALL keep the earlier value and index.
REQ-025 Comparisons SHALL use the full DATA_WIDTH, signed or unsigned per latched is_signed; lanes SHALL be independent.
REQ-026 Accepting beat number len-1 SHALL move the block to OUT; out_valid SHALL rise the cycle after that beat (latency 1).
REQ-027 OUT: out_valid=1 and out_data/out_idx SHALL hold stable until out_ready=1; then return to IDLE the next cycle.
REQ-028 A start asserted in the same cycle as the out_valid/out_ready handshake SHALL be ignored.
REQ-029 len = 2^LEN_WIDTH-1 SHALL be supported without counter wrap; indices range 0..len-1.

Reset
REQ-030 reset SHALL asynchronously force IDLE, in_ready=0, out_valid=0, busy=0, out_data=0, out_idx=0, counter=0.
REQ-031 reset asserted mid-ACC or mid-OUT SHALL discard the partial/pending result; no out_valid after release.
REQ-032 The first start after reset deassertion SHALL be honoured on the first rising edge with reset low.

Configuration
REQ-033 Macro CMP_REDUCE_ARGIDX_EN SHALL compile index tracking in or out.
REQ-034 With CMP_REDUCE_ARGIDX_EN defined, out_idx SHALL carry per-lane argmax/argmin per REQ-023/024; without it, out_idx SHALL be tied to 0 and no index registers shall exist.

Verification
REQ-035 Unsigned max, len=3, lane0 beats 8'h05,8'hF0,8'h10 -> out_data lane0=8'hF0, out_idx lane0=1.
REQ-036 Signed min, len=3, lane1 beats 8'h05,8'hF0,8'h80 -> lane1=8'h80, idx=2; unsigned min same data -> 8'h05, idx=0.
REQ-037 Tie: max, len=4, lane2 beats 7,9,9,3 -> lane2=9, idx=1.
REQ-038 Backpressure: in_valid toggles every cycle, out_ready held 0 for 5 cycles -> out_valid stays 1, outputs stable, start ignored; handshake then IDLE.
REQ-039 start with len=0 -> busy stays 0, in_ready 0, no out_valid.
REQ-040 reset pulse after 2 of 4 beats -> immediate IDLE, out_valid never asserts; fresh len=1 start returns that beat, idx 0.
